matrix_loader: RTL and testbench
================================

// Module: matrix_loader
// PURPOSE
//  Host-side writer for the shared 4K-word matrix memory consumed by the systolic controller.
//  Accepts a valid/ready element stream and writes matrix A, then matrix B (n x n each,
//  row-major) into the memory. Then pulses new_data to start the systolic run.
//  Sits between the host/test interface and the Memory write port, ahead of the controller.
// PARAMETERS
//  WIDTH   16  element width, signed two's complement
//  ADDR_W  12  memory address width (4096 words)
//  N_MAX    4  largest legal matrix dimension (equals array size N)
// PORTS
//  clk            in   1       clock, single domain
//  rst            in   1       synchronous reset, active-high
//  load_start     in   1       1-cycle request to start a load; sampled only in IDLE
//  addr_A         in   ADDR_W  base address of A, latched on accepted load_start
//  addr_B         in   ADDR_W  base address of B, latched on accepted load_start
//  n              in   9       matrix dimension, latched on accepted load_start
//  in_valid       in   1       stream element valid
//  in_data        in   WIDTH   stream element (A row-major, then B row-major)
//  in_ready       out  1       loader can accept an element this cycle
//  mem_wren       out  1       memory write enable (registered)
//  mem_addr       out  ADDR_W  memory write address (registered)
//  mem_data       out  WIDTH   memory write data (registered)
//  new_data       out  1       1-cycle start pulse to the systolic controller
//  busy           out  1       high in LOAD_A/LOAD_B/START
//  done           out  1       1-cycle pulse, same cycle as new_data
//  err            out  1       1-cycle pulse on a rejected load_start
//  err_code       out  2       0 none, 1 n==0 or n>N_MAX, 2 region past 4095, 3 A/B overlap; held until next accepted load_start
//  writes_count   out  32      total memory writes since reset, wraps at 2^32
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0. Reset mid-load aborts; no further writes occur.
//  FSM: IDLE -> (load_start, valid cfg) LOAD_A -> LOAD_B -> START -> IDLE.
//   IDLE, load_start, invalid cfg: err=1 next cycle, err_code set, stay IDLE, no writes.
//  Config checks use 20-bit arithmetic with sz = n*n.
//   Rule 1: n==0 || n>N_MAX.
//   Rule 2: addr_X + sz > 4096, for either base.
//   Rule 3: [A,A+sz) and [B,B+sz) intersect.
//   If several rules fail, the lowest-numbered code wins.
//  in_ready = 1 only in LOAD_A/LOAD_B; 0 in IDLE/START and during reset.
//  Beat = in_valid && in_ready. Element index idx counts 0..sz-1 and resets at each matrix.
//  Beat with idx=k in LOAD_A: next cycle mem_wren=1, mem_addr=addr_A+k, mem_data=in_data.
//   Same rule with addr_B in LOAD_B. Throughput is 1 beat/cycle; back-to-back beats are legal.
//  Without a beat, mem_wren=0 next cycle; mem_addr/mem_data hold their last value.
//  Beat k=sz-1 in LOAD_A: next state LOAD_B, idx cleared. No bubble is required.
//  Beat k=sz-1 in LOAD_B: next state START.
//  The final write (mem_wren) occurs in the START cycle.
//  new_data and done assert in the cycle after START, so the last write has completed.
//   Then the FSM returns to IDLE; busy drops in that same cycle.
//  load_start while busy: ignored, no err.
//  writes_count increments in every cycle where mem_wren=1.
//  Memory is clocked on ~clk; registered outputs therefore meet it half a cycle later.
// TESTING
//  n=2, A=0x000, B=0x010, 8 back-to-back beats 1..8 -> mem writes 0..3=1..4, 0x10..0x13=5..8.
//   Then new_data/done 1 cycle; writes_count=8.
//  Same setup, in_valid toggled 1/0 -> identical contents; mem_wren only after beats; no lost elements.
//  n=0 -> err pulse, err_code=1, no writes. n=5 -> err_code=1.
//   A=0xFFE, n=2 -> err_code=2. A=0x000, B=0x002, n=2 -> err_code=3.
//  rst asserted after 3 beats of A -> in_ready=0 next cycle, all outputs 0, no further writes, no new_data.
//  load_start pulsed during LOAD_B -> ignored; load completes once; new_data pulses exactly once.
//  n=4, A=0xFF0, B=0x000 -> last A write at 0xFFF, no wrap.
//   B writes at 0x000..0x00F; writes_count=32.

Source files
------------

// File: rtl/matrix_loader_if.sv
// rtl/matrix_loader_if.sv - host stream, load config and memory write port bundle for matrix_loader
interface matrix_loader_if #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 12
);
   logic              load_start;
   logic [ADDR_W-1:0] addr_A;
   logic [ADDR_W-1:0] addr_B;
   logic [8:0]        n;
   logic              in_valid;
   logic [WIDTH-1:0]  in_data;
   logic              in_ready;
   logic              mem_wren;
   logic [ADDR_W-1:0] mem_addr;
   logic [WIDTH-1:0]  mem_data;
   logic              new_data;
   logic              busy;
   logic              done;
   logic              err;
   logic [1:0]        err_code;
   logic [31:0]       writes_count;

   modport master (
      output load_start, addr_A, addr_B, n, in_valid, in_data,
      input  in_ready, mem_wren, mem_addr, mem_data, new_data, busy, done,
             err, err_code, writes_count
   );

   modport slave (
      input  load_start, addr_A, addr_B, n, in_valid, in_data,
      output in_ready, mem_wren, mem_addr, mem_data, new_data, busy, done,
             err, err_code, writes_count
   );
endinterface

// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - streams matrix A then B into the shared matrix memory and kicks the systolic run
module matrix_loader #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 12,
   parameter int N_MAX  = 4
) (
   input  logic           clk,
   input  logic           rst,
   matrix_loader_if.slave bus
);
   localparam int CW        = 20;
   localparam int MEM_WORDS = 1 << ADDR_W;
   localparam int IDX_W     = (N_MAX > 1) ? $clog2(N_MAX * N_MAX) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD_A,
      S_LOAD_B,
      S_START
   } state_t;

   state_t            state_q;
   state_t            state_d;

   logic [ADDR_W-1:0] addr_a_q;
   logic [ADDR_W-1:0] addr_b_q;
   logic [IDX_W-1:0]  idx_q;
   logic [IDX_W-1:0]  last_idx_q;

   logic              mem_wren_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [WIDTH-1:0]  mem_data_q;
   logic              new_data_q;
   logic              err_q;
   logic [1:0]        err_code_q;
   logic [31:0]       writes_count_q;

   logic [CW-1:0]     n_w;
   logic [CW-1:0]     sz_w;
   logic [CW-1:0]     a_w;
   logic [CW-1:0]     b_w;
   logic              bad_n;
   logic              bad_range;
   logic              bad_overlap;
   logic [1:0]        cfg_code;
   logic [IDX_W-1:0]  last_idx_d;

   // Region checks are done wide enough that base + size never wraps.
   always_comb begin
      n_w         = CW'(bus.n);
      sz_w        = n_w * n_w;
      a_w         = CW'(bus.addr_A);
      b_w         = CW'(bus.addr_B);
      bad_n       = (n_w == '0) || (n_w > CW'(N_MAX));
      bad_range   = ((a_w + sz_w) > CW'(MEM_WORDS)) || ((b_w + sz_w) > CW'(MEM_WORDS));
      bad_overlap = (a_w < (b_w + sz_w)) && (b_w < (a_w + sz_w));
      last_idx_d  = IDX_W'(sz_w - CW'(1));
      if (bad_n) begin
         cfg_code = 2'd1;
      end else if (bad_range) begin
         cfg_code = 2'd2;
      end else if (bad_overlap) begin
         cfg_code = 2'd3;
      end else begin
         cfg_code = 2'd0;
      end
   end

   logic              loading;
   logic              in_ready;
   logic              beat;
   logic              last_beat;
   logic              start_req;
   logic              start_ok;
   logic              start_bad;
   logic [ADDR_W-1:0] wr_base;
   logic [ADDR_W-1:0] wr_addr;

   always_comb begin
      state_d   = state_q;
      loading   = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
      in_ready  = loading && !rst;
      beat      = in_ready && bus.in_valid;
      last_beat = beat && (idx_q == last_idx_q);
      start_req = (state_q == S_IDLE) && bus.load_start;
      start_ok  = start_req && (cfg_code == 2'd0);
      start_bad = start_req && (cfg_code != 2'd0);
      wr_base   = (state_q == S_LOAD_A) ? addr_a_q : addr_b_q;
      wr_addr   = wr_base + ADDR_W'(idx_q);
      case (state_q)
         S_IDLE:   if (start_ok)  state_d = S_LOAD_A;
         S_LOAD_A: if (last_beat) state_d = S_LOAD_B;
         S_LOAD_B: if (last_beat) state_d = S_START;
         S_START:                 state_d = S_IDLE;
         default:                 state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_a_q       <= '0;
         addr_b_q       <= '0;
         idx_q          <= '0;
         last_idx_q     <= '0;
         mem_wren_q     <= 1'b0;
         mem_addr_q     <= '0;
         mem_data_q     <= '0;
         new_data_q     <= 1'b0;
         err_q          <= 1'b0;
         err_code_q     <= 2'd0;
         writes_count_q <= '0;
      end else begin
         mem_wren_q     <= beat;
         new_data_q     <= (state_q == S_START);
         err_q          <= start_bad;
         writes_count_q <= writes_count_q + 32'(mem_wren_q);
         if (beat) begin
            mem_addr_q <= wr_addr;
            mem_data_q <= bus.in_data;
            idx_q      <= last_beat ? '0 : idx_q + IDX_W'(1);
         end
         if (start_ok) begin
            addr_a_q   <= bus.addr_A;
            addr_b_q   <= bus.addr_B;
            last_idx_q <= last_idx_d;
            idx_q      <= '0;
            err_code_q <= 2'd0;
         end else if (start_bad) begin
            err_code_q <= cfg_code;
         end
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.busy         = (state_q != S_IDLE) && !rst;
   assign bus.mem_wren     = mem_wren_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_data     = mem_data_q;
   assign bus.new_data     = new_data_q;
   assign bus.done         = new_data_q;
   assign bus.err          = err_q;
   assign bus.err_code     = err_code_q;
   assign bus.writes_count = writes_count_q;
endmodule

// File: tb/tb_matrix_loader.sv
// tb/tb_matrix_loader.sv - directed self-checking bench for matrix_loader
module tb_matrix_loader;
   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks = 0;
   int errors = 0;
   int exp_wc = 0;
   int wr_seen = 0;
   int nd_pulses = 0;
   int err_pulses = 0;
   int snap_wr;
   int snap_nd;
   int snap_err;

   logic [15:0] mem [0:4095];

   matrix_loader_if #(.WIDTH(16), .ADDR_W(12)) bus ();

   matrix_loader #(.WIDTH(16), .ADDR_W(12), .N_MAX(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Memory model sits on the falling edge, like the real shared memory.
   always @(negedge clk) begin
      if (bus.mem_wren === 1'b1) begin
         mem[bus.mem_addr] = bus.mem_data;
         wr_seen++;
      end
      if (bus.new_data === 1'b1) nd_pulses++;
      if (bus.err === 1'b1) err_pulses++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input int nn, input logic [11:0] a, input logic [11:0] b);
      bus.n          = 9'(nn);
      bus.addr_A     = a;
      bus.addr_B     = b;
      bus.load_start = 1'b1;
      step();
      bus.load_start = 1'b0;
   endtask

   task automatic stream_load(input int nn, input logic [11:0] a, input logic [11:0] b,
                              input int first, input bit toggle, input int poke);
      int  sz;
      int  sent;
      int  cyc;
      bit  v;
      sz   = nn * nn;
      sent = 0;
      cyc  = 0;
      while (sent < 2 * sz && cyc < 400) begin
         v = toggle ? ((cyc % 2) == 0) : 1'b1;
         bus.in_valid = v;
         bus.in_data  = 16'(first + sent);
         if (v && sent == poke) begin
            bus.load_start = 1'b1;
            bus.n          = 9'd0;
         end
         check("in_ready_during_load", 32'(bus.in_ready), 32'd1);
         step();
         bus.load_start = 1'b0;
         bus.n          = 9'(nn);
         check("mem_wren_follows_beat", 32'(bus.mem_wren), 32'(v));
         if (v) begin
            check("mem_addr", 32'(bus.mem_addr),
                  (sent < sz) ? 32'(12'(a + 12'(sent))) : 32'(12'(b + 12'(sent - sz))));
            check("mem_data", 32'(bus.mem_data), 32'(16'(first + sent)));
            sent++;
         end
         cyc++;
      end
      bus.in_valid = 1'b0;
      check("stream_complete", 32'(sent), 32'(2 * sz));
   endtask

   task automatic expect_finish();
      check("busy_in_start", 32'(bus.busy), 32'd1);
      check("new_data_not_early", 32'(bus.new_data), 32'd0);
      step();
      check("new_data_pulse", 32'(bus.new_data), 32'd1);
      check("done_pulse", 32'(bus.done), 32'd1);
      check("busy_dropped", 32'(bus.busy), 32'd0);
      check("in_ready_idle", 32'(bus.in_ready), 32'd0);
      check("no_write_after_start", 32'(bus.mem_wren), 32'd0);
      check("writes_count", bus.writes_count, 32'(exp_wc));
      step();
      check("new_data_single", 32'(bus.new_data), 32'd0);
      check("done_single", 32'(bus.done), 32'd0);
   endtask

   task automatic expect_reject(input int nn, input logic [11:0] a, input logic [11:0] b,
                                input int code, input string tag);
      snap_wr = wr_seen;
      start_load(nn, a, b);
      check({tag, "_err"}, 32'(bus.err), 32'd1);
      check({tag, "_code"}, 32'(bus.err_code), 32'(code));
      check({tag, "_idle"}, 32'(bus.busy), 32'd0);
      step();
      check({tag, "_err_pulse"}, 32'(bus.err), 32'd0);
      check({tag, "_code_held"}, 32'(bus.err_code), 32'(code));
      check({tag, "_no_write"}, 32'(wr_seen), 32'(snap_wr));
      check({tag, "_wc_same"}, bus.writes_count, 32'(exp_wc));
   endtask

   initial begin
      bus.load_start = 1'b0;
      bus.addr_A     = '0;
      bus.addr_B     = '0;
      bus.n          = '0;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      clear_mem();

      repeat (3) step();
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      rst = 1'b0;
      step();
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_wren", 32'(bus.mem_wren), 32'd0);
      check("rst_addr", 32'(bus.mem_addr), 32'd0);
      check("rst_data", 32'(bus.mem_data), 32'd0);
      check("rst_new_data", 32'(bus.new_data), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      check("rst_err_code", 32'(bus.err_code), 32'd0);
      check("rst_wc", bus.writes_count, 32'd0);

      // Back-to-back 2x2 load.
      start_load(2, 12'h000, 12'h010);
      check("busy_after_start", 32'(bus.busy), 32'd1);
      stream_load(2, 12'h000, 12'h010, 1, 1'b0, -1);
      exp_wc += 8;
      expect_finish();
      for (int i = 0; i < 4; i++) begin
         check("bb_mem_a", 32'(mem[i]), 32'(i + 1));
         check("bb_mem_b", 32'(mem[16 + i]), 32'(i + 5));
      end

      // Same load with gaps in in_valid.
      clear_mem();
      start_load(2, 12'h000, 12'h010);
      stream_load(2, 12'h000, 12'h010, 1, 1'b1, -1);
      exp_wc += 8;
      expect_finish();
      for (int i = 0; i < 4; i++) begin
         check("gap_mem_a", 32'(mem[i]), 32'(i + 1));
         check("gap_mem_b", 32'(mem[16 + i]), 32'(i + 5));
      end

      expect_reject(0, 12'h000, 12'h040, 1, "n0");
      expect_reject(5, 12'h000, 12'h040, 1, "n5");
      expect_reject(2, 12'hFFE, 12'h000, 2, "range");
      expect_reject(2, 12'h000, 12'h002, 3, "overlap");

      // load_start poked mid LOAD_B must be ignored.
      snap_nd  = nd_pulses;
      snap_err = err_pulses;
      start_load(2, 12'h020, 12'h030);
      check("code_cleared", 32'(bus.err_code), 32'd0);
      stream_load(2, 12'h020, 12'h030, 9, 1'b0, 5);
      exp_wc += 8;
      expect_finish();
      repeat (3) step();
      check("poke_single_new_data", 32'(nd_pulses), 32'(snap_nd + 1));
      check("poke_no_err", 32'(err_pulses), 32'(snap_err));
      check("poke_idle", 32'(bus.busy), 32'd0);
      check("poke_mem_b_last", 32'(mem[12'h033]), 32'd16);

      // Reset after three beats of A.
      snap_wr = wr_seen;
      snap_nd = nd_pulses;
      start_load(2, 12'h100, 12'h200);
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 16'(16'h50 + i);
         step();
      end
      rst = 1'b1;
      step();
      check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
      check("midrst_wren", 32'(bus.mem_wren), 32'd0);
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_addr", 32'(bus.mem_addr), 32'd0);
      check("midrst_data", 32'(bus.mem_data), 32'd0);
      check("midrst_wc", bus.writes_count, 32'd0);
      rst = 1'b0;
      exp_wc = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("postrst_in_ready", 32'(bus.in_ready), 32'd0);
         check("postrst_wren", 32'(bus.mem_wren), 32'd0);
      end
      bus.in_valid = 1'b0;
      check("midrst_writes", 32'(wr_seen), 32'(snap_wr + 3));
      check("midrst_no_new_data", 32'(nd_pulses), 32'(snap_nd));

      // 4x4 with A ending exactly at the top of memory.
      clear_mem();
      start_load(4, 12'hFF0, 12'h000);
      stream_load(4, 12'hFF0, 12'h000, 1, 1'b0, -1);
      exp_wc += 32;
      expect_finish();
      check("top_first_a", 32'(mem[12'hFF0]), 32'd1);
      check("top_last_a", 32'(mem[12'hFFF]), 32'd16);
      check("top_first_b", 32'(mem[12'h000]), 32'd17);
      check("top_last_b", 32'(mem[12'h00F]), 32'd32);
      check("top_no_spill", 32'(mem[12'h010]), 32'd0);
      check("top_wc", bus.writes_count, 32'd32);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
